// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control path, the counter datapath and
// the testbench.
//   sw_state_e          : FSM state encoding as seen on state_o
//   DEB_CYCLES_DEFAULT  : default debounce length (10 ms at 50 MHz)
//   is_counting()       : states in which centisecond ticks advance the counters
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int DEB_CYCLES_DEFAULT = 500000;

  // LAP keeps the live count running; only the display is frozen.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push-button conditioning lane: 2-FF synchronizer, debounce filter, and
// rising-edge detection of the debounced level.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   btn_raw  in   raw asynchronous button level, active-high
//   press_o  out  one-cycle pulse when the debounced level goes 0 -> 1
// Parameters:
//   DEB_CYCLES  consecutive cycles the synced level must differ from the
//               stable level before it is accepted
//   DEB_W       counter width (derived)
// Latency from a clean raw edge to press_o is 2 + DEB_CYCLES cycles.
// -----------------------------------------------------------------------------
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_o
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q,  sync1_d;
  logic             sync2_q,  sync2_d;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q,    cnt_d;
  logic             press_q,  press_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;

    if (sync2_q == stable_q) begin
      // Level agrees with the accepted one: any partial glitch count is void.
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      // DEB_CYCLES consecutive disagreeing cycles: accept the new level.
      // The edge detect is folded in here, so only a 0 -> 1 acceptance
      // produces a press and release stays silent.
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM for the BCD stopwatch counter chain. Conditions three raw
// buttons into one-cycle press events and sequences the counters and the
// split/lap capture path.
// Ports:
//   clk          in   system clock, single domain
//   rst          in   synchronous, active-high reset
//   tick_cent    in   one-cycle pulse per 1/100 s
//   btn_ss       in   raw start/stop button
//   btn_split    in   raw split/lap button
//   btn_clr      in   raw clear button
//   cnt_en       out  one-cycle increment strobe (tick_cent delayed by 1)
//   cnt_clr      out  one-cycle clear of counters and split registers
//   split_latch  out  one-cycle capture strobe for the split registers
//   disp_hold    out  1 = display shows split registers
//   state_o      out  current FSM state (IDLE=00 RUN=01 PAUSE=10 LAP=11)
// Strobe semantics: every strobe output is a registered single-cycle pulse
// appearing the cycle after the event that caused it; there is no handshake,
// downstream logic must act on the pulse in that cycle.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_cent,
  input  logic       btn_ss,
  input  logic       btn_split,
  input  logic       btn_clr,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       split_latch,
  output logic       disp_hold,
  output logic [1:0] state_o
);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic ss_press;
  logic split_press;
  logic clr_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .press_o (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_split (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_split),
    .press_o (split_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr),
    .press_o (clr_press)
  );

  // ---------------------------------------------------------------------------
  // Event arbitration: clr > ss > split. A masked event is lost for good,
  // even when the winning event is itself ignored in the current state
  // (e.g. clr+ss in RUN leaves the FSM in RUN).
  // ---------------------------------------------------------------------------
  logic ev_clr;
  logic ev_ss;
  logic ev_split;

  always_comb begin
    ev_clr   = clr_press;
    ev_ss    = ss_press & ~clr_press;
    ev_split = split_press & ~clr_press & ~ss_press;
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  sw_state_e state_q,       state_d;
  logic      cnt_en_q,      cnt_en_d;
  logic      cnt_clr_q,     cnt_clr_d;
  logic      split_latch_q, split_latch_d;
  logic      disp_hold_q,   disp_hold_d;

  always_comb begin
    state_d       = state_q;
    split_latch_d = 1'b0;
    cnt_clr_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev_ss) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss) begin
          state_d = ST_PAUSE;
        end else if (ev_split) begin
          state_d       = ST_LAP;
          split_latch_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_clr) begin
          state_d = ST_RUN;
        end else if (ev_ss) begin
          state_d = ST_PAUSE;
        end else if (ev_split) begin
          // New lap: stay frozen but recapture the live count.
          state_d       = ST_LAP;
          split_latch_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (ev_ss) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Gated by the current state register, so a tick landing in the same
    // cycle as a stop event still counts once.
    cnt_en_d = tick_cent & is_counting(state_q);

    // Registered alongside state_q, so it always equals (state_q == ST_LAP).
    disp_hold_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_en_q      <= 1'b0;
      cnt_clr_q     <= 1'b0;
      split_latch_q <= 1'b0;
      disp_hold_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_en_q      <= cnt_en_d;
      cnt_clr_q     <= cnt_clr_d;
      split_latch_q <= split_latch_d;
      disp_hold_q   <= disp_hold_d;
    end
  end

  assign cnt_en      = cnt_en_q;
  assign cnt_clr     = cnt_clr_q;
  assign split_latch = split_latch_q;
  assign disp_hold   = disp_hold_q;
  assign state_o     = state_q;

endmodule
